// File: rtl/aclk_controller.sv
// aclk_controller: keypad/button sequencer for the alarm clock.
// It collects up to four BCD digits into a staging register.
// It strobes the counter or the alarm register to load those digits.
// It selects what the display shows.
// It abandons an idle entry after TIMEOUT_S one-second ticks.
module aclk_controller #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_alarm,
  output logic       shift,
  output logic       entry_error
);

  typedef enum logic [2:0] {
    S_SHOW_TIME,
    S_KEY_STORED,
    S_KEY_WAITED,
    S_KEY_ENTRY,
    S_SHOW_ALARM,
    S_SET_ALARM_TIME,
    S_SET_CURRENT_TIME,
    S_ERROR
  } state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_S - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_tcnt;
  logic [3:0] r_key_hold;
  logic [3:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic       r_load_c, r_load_a, r_show_new, r_show_alarm, r_shift, r_entry_error;

  logic w_is_digit;
  logic w_timeout;
  logic w_valid;

  assign w_is_digit = (key <= 4'd9);
  assign w_timeout  = one_second && (r_tcnt == TIMEOUT_LAST);

  // The staging digits are a valid 24-hour time (00:00 .. 23:59).
  assign w_valid = (r_ms_hr <= 4'd2) &&
                   ((r_ms_hr == 4'd2) ? (r_ls_hr <= 4'd3) : (r_ls_hr <= 4'd9)) &&
                   (r_ms_min <= 4'd5) && (r_ls_min <= 4'd9);

  // Next-state logic.
  // The staging value is validated on the button edge out of KEY_ENTRY.
  // It cannot change between KEY_ENTRY and the following state.
  // A bad value therefore goes straight to ERROR.
  // That keeps the load/error pulse exactly one cycle after the button.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_SHOW_TIME: begin
        if (alarm_button)    w_next_state = S_SHOW_ALARM;
        else if (w_is_digit) w_next_state = S_KEY_STORED;
      end
      S_KEY_STORED: w_next_state = S_KEY_WAITED;
      S_KEY_WAITED: begin
        if (!w_is_digit)    w_next_state = S_KEY_ENTRY;
        else if (w_timeout) w_next_state = S_SHOW_TIME;
      end
      S_KEY_ENTRY: begin
        if (alarm_button)     w_next_state = w_valid ? S_SET_ALARM_TIME : S_ERROR;
        else if (time_button) w_next_state = w_valid ? S_SET_CURRENT_TIME : S_ERROR;
        else if (w_is_digit)  w_next_state = S_KEY_STORED;
        else if (w_timeout)   w_next_state = S_SHOW_TIME;
      end
      S_SHOW_ALARM:       if (!alarm_button) w_next_state = S_SHOW_TIME;
      S_SET_ALARM_TIME:   w_next_state = S_SHOW_TIME;
      S_SET_CURRENT_TIME: w_next_state = S_SHOW_TIME;
      S_ERROR:            w_next_state = S_SHOW_TIME;
      default:            w_next_state = S_SHOW_TIME;
    endcase
  end

  // State register with outputs registered from the next state.
  // Each output is therefore a clean flop that tracks the state one-for-one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_SHOW_TIME;
      r_load_c      <= 1'b0;
      r_load_a      <= 1'b0;
      r_show_new    <= 1'b0;
      r_show_alarm  <= 1'b0;
      r_shift       <= 1'b0;
      r_entry_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state       <= w_next_state;
      r_load_c      <= (w_next_state == S_SET_CURRENT_TIME);
      r_load_a      <= (w_next_state == S_SET_ALARM_TIME);
      r_show_new    <= (w_next_state inside {S_KEY_STORED, S_KEY_WAITED, S_KEY_ENTRY,
                                             S_SET_ALARM_TIME, S_SET_CURRENT_TIME, S_ERROR});
      r_show_alarm  <= (w_next_state == S_SHOW_ALARM);
      r_shift       <= (w_next_state == S_KEY_STORED);
      r_entry_error <= (w_next_state == S_ERROR);
    end
  end

  // Idle timeout counter.
  // It restarts on every state change and counts seconds while waiting for input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= 4'd0;
    end else if (w_next_state != r_state) begin
      r_tcnt <= 4'd0;
    end else if (one_second && (r_state == S_KEY_WAITED || r_state == S_KEY_ENTRY)) begin
      r_tcnt <= r_tcnt + 4'd1;
    end
  end

  // Staging register and key hold.
  // A fresh entry clears the staging digits.
  // Each stored key shifts in from the right, and the oldest digit drops out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_hold <= 4'd0;
      r_ms_hr    <= 4'd0;
      r_ls_hr    <= 4'd0;
      r_ms_min   <= 4'd0;
      r_ls_min   <= 4'd0;
    end else begin
      case (r_state)
        S_SHOW_TIME: begin
          if (w_next_state == S_KEY_STORED) begin
            r_key_hold <= key;
            r_ms_hr    <= 4'd0;
            r_ls_hr    <= 4'd0;
            r_ms_min   <= 4'd0;
            r_ls_min   <= 4'd0;
          end
        end
        S_KEY_ENTRY: begin
          if (w_next_state == S_KEY_STORED) r_key_hold <= key;
        end
        S_KEY_STORED: begin
          r_ms_hr  <= r_ls_hr;
          r_ls_hr  <= r_ms_min;
          r_ms_min <= r_ls_min;
          r_ls_min <= r_key_hold;
        end
        default: ;
      endcase
    end
  end

  assign new_time_ms_hr  = r_ms_hr;
  assign new_time_ls_hr  = r_ls_hr;
  assign new_time_ms_min = r_ms_min;
  assign new_time_ls_min = r_ls_min;
  assign load_new_c      = r_load_c;
  assign load_new_a      = r_load_a;
  assign show_new_time   = r_show_new;
  assign show_alarm      = r_show_alarm;
  assign shift           = r_shift;
  assign entry_error     = r_entry_error;

endmodule

// File: tb/tb_aclk_controller.sv
// Directed testbench for aclk_controller.
// Each scenario task drives keys and buttons and checks outputs one time unit after the rising edge.
module tb_aclk_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min;
  logic       load_new_c, load_new_a, show_new_time, show_alarm, shift, entry_error;

  int n_checks = 0;
  int n_errors = 0;

  aclk_controller #(.TIMEOUT_S(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .one_second      (one_second),
    .key             (key),
    .alarm_button    (alarm_button),
    .time_button     (time_button),
    .new_time_ms_hr  (new_time_ms_hr),
    .new_time_ls_hr  (new_time_ls_hr),
    .new_time_ms_min (new_time_ms_min),
    .new_time_ls_min (new_time_ls_min),
    .load_new_c      (load_new_c),
    .load_new_a      (load_new_a),
    .show_new_time   (show_new_time),
    .show_alarm      (show_alarm),
    .shift           (shift),
    .entry_error     (entry_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] staging();
    return {new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min};
  endfunction

  // {load_new_c, load_new_a, show_new_time, show_alarm, shift, entry_error}
  function automatic logic [5:0] outs();
    return {load_new_c, load_new_a, show_new_time, show_alarm, shift, entry_error};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press one digit from an idle or entry state and release it.
  // This leaves the FSM in KEY_ENTRY and returns how many cycles shift was high.
  task automatic press(input logic [3:0] d, output int shifts);
    shifts = 0;
    key = d;
    tick();
    if (shift) shifts++;
    key = 4'hA;
    tick();
    if (shift) shifts++;
    tick();
    if (shift) shifts++;
  endtask

  task automatic test_reset();
    key = 4'hA; alarm_button = 0; time_button = 0; one_second = 0;
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (outs() !== 6'b0) begin
      n_errors++; $display("FAIL reset_outs: got %b expected %b", outs(), 6'b0);
    end
    n_checks++;
    if (staging() !== 16'h0000) begin
      n_errors++; $display("FAIL reset_staging: got %h expected %h", staging(), 16'h0000);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b0) begin
      n_errors++; $display("FAIL reset_idle_outs: got %b expected %b", outs(), 6'b0);
    end
  endtask

  task automatic test_time_load();
    logic [3:0] digits [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    int sh;
    for (int i = 0; i < 4; i++) begin
      press(digits[i], sh);
      n_checks++;
      if (sh !== 1) begin
        n_errors++; $display("FAIL time_shift_count[%0d]: got %0d expected 1", i, sh);
      end
    end
    n_checks++;
    if (staging() !== 16'h1234 || show_new_time !== 1'b1) begin
      n_errors++; $display("FAIL time_staging: got %h/%b expected 1234/1", staging(), show_new_time);
    end
    time_button = 1;
    tick();
    time_button = 0;
    n_checks++;
    if (outs() !== 6'b101000) begin
      n_errors++; $display("FAIL time_load_pulse: got %b expected %b", outs(), 6'b101000);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b0 || staging() !== 16'h1234) begin
      n_errors++; $display("FAIL time_after_load: got %b/%h expected 000000/1234", outs(), staging());
    end
  endtask

  task automatic test_alarm_load();
    logic [3:0] digits [4] = '{4'd0, 4'd7, 4'd3, 4'd0};
    int sh;
    for (int i = 0; i < 4; i++) press(digits[i], sh);
    alarm_button = 1; time_button = 1;
    tick();
    n_checks++;
    if (outs() !== 6'b011000) begin
      n_errors++; $display("FAIL alarm_load_pulse: got %b expected %b", outs(), 6'b011000);
    end
    // Buttons still held: first back to SHOW_TIME, then SHOW_ALARM.
    tick();
    n_checks++;
    if (outs() !== 6'b0 || staging() !== 16'h0730) begin
      n_errors++; $display("FAIL alarm_after_load: got %b/%h expected 000000/0730", outs(), staging());
    end
    tick();
    n_checks++;
    if (outs() !== 6'b000100) begin
      n_errors++; $display("FAIL alarm_held_show: got %b expected %b", outs(), 6'b000100);
    end
    alarm_button = 0; time_button = 0;
    tick();
    n_checks++;
    if (outs() !== 6'b0) begin
      n_errors++; $display("FAIL alarm_release: got %b expected %b", outs(), 6'b0);
    end
  endtask

  task automatic test_entry_error();
    logic [3:0] digits [4] = '{4'd2, 4'd5, 4'd0, 4'd0};
    int sh;
    for (int i = 0; i < 4; i++) press(digits[i], sh);
    time_button = 1;
    tick();
    time_button = 0;
    n_checks++;
    if (outs() !== 6'b001001) begin
      n_errors++; $display("FAIL error_pulse: got %b expected %b", outs(), 6'b001001);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b0 || staging() !== 16'h2500) begin
      n_errors++; $display("FAIL error_after: got %b/%h expected 000000/2500", outs(), staging());
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] ok [4]   = '{4'd2, 4'd3, 4'd5, 4'd9};
    logic [3:0] bad [4]  = '{4'd2, 4'd4, 4'd0, 4'd0};
    logic [3:0] five [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    int sh;
    // 23:59 is the largest valid time.
    for (int i = 0; i < 4; i++) press(ok[i], sh);
    time_button = 1; tick(); time_button = 0;
    n_checks++;
    if (outs() !== 6'b101000) begin
      n_errors++; $display("FAIL bound_2359: got %b expected %b", outs(), 6'b101000);
    end
    tick();
    // 24:00 is rejected.
    for (int i = 0; i < 4; i++) press(bad[i], sh);
    alarm_button = 1; tick(); alarm_button = 0;
    n_checks++;
    if (outs() !== 6'b001001) begin
      n_errors++; $display("FAIL bound_2400: got %b expected %b", outs(), 6'b001001);
    end
    tick();
    // A fifth digit pushes out the oldest one.
    for (int i = 0; i < 5; i++) press(five[i], sh);
    n_checks++;
    if (staging() !== 16'h2345) begin
      n_errors++; $display("FAIL five_digits: got %h expected %h", staging(), 16'h2345);
    end
    alarm_button = 1; tick(); alarm_button = 0;
    n_checks++;
    if (outs() !== 6'b011000) begin
      n_errors++; $display("FAIL five_digits_load: got %b expected %b", outs(), 6'b011000);
    end
    tick();
  endtask

  task automatic test_held_key_timeout();
    int shifts = 0;
    int loads  = 0;
    key = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (shift) shifts++;
    end
    key = 4'hA;
    tick();
    if (shift) shifts++;
    n_checks++;
    if (shifts !== 1 || staging() !== 16'h0009) begin
      n_errors++; $display("FAIL held_key: got shifts=%0d staging=%h expected 1/0009", shifts, staging());
    end
    for (int t = 1; t <= 10; t++) begin
      one_second = 1;
      tick();
      one_second = 0;
      if (load_new_c || load_new_a) loads++;
      if (t == 9) begin
        n_checks++;
        if (show_new_time !== 1'b1) begin
          n_errors++; $display("FAIL timeout_tick9: got show_new_time=%b expected 1", show_new_time);
        end
      end
      if (t == 10) begin
        n_checks++;
        if (show_new_time !== 1'b0) begin
          n_errors++; $display("FAIL timeout_tick10: got show_new_time=%b expected 0", show_new_time);
        end
      end
      tick();
      if (load_new_c || load_new_a) loads++;
    end
    n_checks++;
    if (loads !== 0 || staging() !== 16'h0009) begin
      n_errors++; $display("FAIL timeout_noload: got loads=%0d staging=%h expected 0/0009", loads, staging());
    end
  endtask

  task automatic test_show_alarm();
    alarm_button = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (outs() !== 6'b000100) begin
        n_errors++; $display("FAIL show_alarm_cycle%0d: got %b expected %b", i, outs(), 6'b000100);
      end
    end
    alarm_button = 0;
    tick();
    n_checks++;
    if (show_alarm !== 1'b0) begin
      n_errors++; $display("FAIL show_alarm_release: got %b expected 0", show_alarm);
    end
  endtask

  task automatic test_reset_mid_entry();
    int sh;
    press(4'd4, sh);
    press(4'd2, sh);
    n_checks++;
    if (staging() !== 16'h0042) begin
      n_errors++; $display("FAIL mid_entry_staging: got %h expected %h", staging(), 16'h0042);
    end
    // Reset dominates a digit and a button presented on the same edge.
    reset = 1; key = 4'd5; alarm_button = 1;
    tick();
    reset = 0; key = 4'hA; alarm_button = 0;
    n_checks++;
    if (outs() !== 6'b0 || staging() !== 16'h0000) begin
      n_errors++; $display("FAIL mid_entry_reset: got %b/%h expected 000000/0000", outs(), staging());
    end
    tick();
    n_checks++;
    if (outs() !== 6'b0) begin
      n_errors++; $display("FAIL mid_entry_idle: got %b expected %b", outs(), 6'b0);
    end
  endtask

  initial begin
    reset = 1; key = 4'hA; alarm_button = 0; time_button = 0; one_second = 0;
    tick();
    tick();
    test_reset();
    test_time_load();
    test_alarm_load();
    test_entry_error();
    test_boundaries();
    test_held_key_timeout();
    test_show_alarm();
    test_reset_mid_entry();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aclk_controller.md
# aclk_controller

Keypad/button sequencer for the alarm clock. It captures up to four BCD digits into a staging register and drives the load strobes of the time counter (`load_new_c`) and the alarm register (`load_new_a`). It also selects what the display shows and abandons an idle entry after a seconds-based timeout. It sits between the keypad scanner and the counter/alarm-register/display-mux datapath.

## Interface
Parameters:
- TIMEOUT_S, 10: count of `one_second` pulses before an idle or stuck entry is abandoned (range 1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- one_second  in  1  one-cycle tick, once per second.
- key  in  4  0-9 = digit pressed; 4'hA = no key; 4'hB-4'hF are treated as no key.
- alarm_button  in  1  level; alarm set/show request.
- time_button  in  1  level; time set request.
- new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min  out  4 each  staging digits; drive the `new_current_time_*` inputs of the counter and the alarm register.
- load_new_c  out  1  one-cycle strobe: counter loads the staging digits.
- load_new_a  out  1  one-cycle strobe: alarm register loads the staging digits.
- show_new_time  out  1  display shows the staging digits.
- show_alarm  out  1  display shows the stored alarm time.
- shift  out  1  high in the cycle a digit is shifted in (debug/beeper).
- entry_error  out  1  one-cycle pulse: the entered value was not a valid time; nothing was loaded.

## Operation
- FSM states are SHOW_TIME (reset state), KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME and ERROR.
- A digit is `key` <= 9.
- SHOW_TIME:
  - `alarm_button`=1 -> SHOW_ALARM.
  - Otherwise a digit -> KEY_STORED. On the same edge the staging register clears to 0000 and the digit is held in `key_hold`.
  - `time_button` alone is ignored.
- KEY_STORED:
  - `shift`=1. On the leaving edge the staging register shifts left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=`key_hold`.
  - Always -> KEY_WAITED.
- KEY_WAITED:
  - `key` not a digit -> KEY_ENTRY.
  - Timeout -> SHOW_TIME.
- KEY_ENTRY: priority order is
  - `alarm_button` -> SET_ALARM_TIME;
  - `time_button` -> SET_CURRENT_TIME;
  - digit -> KEY_STORED (`key_hold` captured);
  - timeout -> SHOW_TIME.
- SHOW_ALARM: stay while `alarm_button`=1, else -> SHOW_TIME.
- SET_ALARM_TIME and SET_CURRENT_TIME:
  - Valid staging value (ms_hr<=2; ls_hr<=3 if ms_hr==2, else <=9; ms_min<=5; ls_min<=9): assert `load_new_a` or `load_new_c` respectively for one cycle -> SHOW_TIME.
  - Invalid value -> ERROR, with no load.
- ERROR: `entry_error`=1 for one cycle -> SHOW_TIME.
- More than four digits: the oldest digit is shifted out, with no wrap protection needed.
- Timeout counter (4-bit):
  - Clears on every state change.
  - Increments on `one_second` in KEY_WAITED and KEY_ENTRY.
  - Timeout occurs when the counter == TIMEOUT_S-1 and `one_second`=1.
- Output decode (Moore, from the state register only):
  - `show_new_time`=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_*, ERROR.
  - `show_alarm`=1 in SHOW_ALARM.
  - All other outputs are 0 outside their states.
- The staging register holds its value after a load, timeout or error until the next fresh entry clears it.

## Timing
- Reset, whenever it is sampled high, mid-entry included, has this effect:
  - State becomes SHOW_TIME; timeout counter = 0; staging = 0000; `key_hold` = 0.
  - All outputs are 0 from the following cycle.
  - Reset dominates every other input.
- Digit sampled at edge N in SHOW_TIME/KEY_ENTRY:
  - `shift`=1 in cycle N+1.
  - New staging value visible from cycle N+2.
- Button sampled at edge N in KEY_ENTRY: `load_new_*` or `entry_error` is high for exactly cycle N+1, and the state is SHOW_TIME in cycle N+2.
- A held key produces exactly one shift; a new digit needs release (non-digit) first.
- `one_second` coinciding with a transition out of KEY_ENTRY: the transition wins and the counter clears.
- Buttons held through a load: SHOW_TIME re-evaluates them one cycle later. A still-held `alarm_button` therefore enters SHOW_ALARM, which is intended.

## Test plan
- Reset with keys idle -> all outputs 0, state SHOW_TIME, staging 0000.
- Keys 1,2,3,4, each with release, then `time_button` -> staging 1234, `load_new_c` high exactly one cycle, `show_new_time` low afterwards.
- Keys 0,7,3,0 then `alarm_button` (with `time_button` also high) -> `load_new_a` pulse only, staging 0730.
- Keys 2,5,0,0 then `time_button` -> `entry_error` pulse, no `load_new_c`.
- Key 9 held for 3 cycles, then released, then no activity for 10 `one_second` ticks -> a single shift (staging 0009), return to SHOW_TIME on the 10th tick, no load.
- `alarm_button` held 5 cycles from SHOW_TIME -> `show_alarm`=1 throughout; reset asserted mid-entry after two digits -> staging 0000 and SHOW_TIME on the next cycle.
